// File: rtl/prog_activation_lut_pkg.sv
// Shared types and helpers for the programmable activation lookup table.
package prog_activation_lut_pkg;

  // Controller states. The table is usable only in RUN.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // no valid table resident, waiting for cfg_start
    LOAD  = 2'd1,  // accepting table entries in address order
    RUN   = 2'd2,  // table complete, lookups enabled
    DRAIN = 2'd3   // reload requested, flushing the pending output
  } lut_state_t;

  // Number of table entries for a given address width.
  function automatic int unsigned lut_depth(input int unsigned width);
    return 32'd1 << width;
  endfunction

endpackage

// File: rtl/activation_lut_mem.sv
// Table storage: simple dual-port RAM with one synchronous write port and a
// registered read port. The read register is also the block's output stage.
// It loads only when a new lookup is accepted, so it holds its value while
// the output is stalled. This keeps the structure inferable as BRAM/LUTRAM
// with the output register used as the RAM's read latch.
module activation_lut_mem
  import prog_activation_lut_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  localparam int unsigned DEPTH = lut_depth(ADDR_WIDTH);

  // Contents are deliberately not reset; a full reload always precedes use.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Write port: one table entry per accepted configuration beat.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read register: captures on an accepted lookup, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/prog_activation_lut.sv
// Runtime-programmable activation LUT. A configuration stream loads every
// table entry in address order, then a valid/ready data stream is looked up
// against the resident table with a one-cycle latency.
//
// Handshake rule for all three streams (cfg, data_in_0, data_out_0): a
// transfer completes on a rising clk edge where valid and ready are both
// high. The sender must hold valid and its data until that edge; ready may
// depend combinationally on the other side's valid/ready.
module prog_activation_lut
  import prog_activation_lut_pkg::*;
#(
  parameter int unsigned DATA_IN_WIDTH  = 8,
  parameter int unsigned DATA_OUT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_start,
  input  logic [DATA_OUT_WIDTH-1:0] cfg_data,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  output logic                      lut_loaded,
  input  logic [DATA_IN_WIDTH-1:0]  data_in_0,
  input  logic                      data_in_0_valid,
  output logic                      data_in_0_ready,
  output logic [DATA_OUT_WIDTH-1:0] data_out_0,
  output logic                      data_out_0_valid,
  input  logic                      data_out_0_ready,
  output lut_state_t                dbg_state
);

  // Address of the final table entry; the beat written here completes a load.
  localparam logic [DATA_IN_WIDTH-1:0] ADDR_LAST = '1;

  lut_state_t                r_state;
  lut_state_t                w_state_next;
  logic [DATA_IN_WIDTH-1:0]  r_addr;
  logic [DATA_IN_WIDTH-1:0]  w_addr_next;
  logic                      r_loaded;
  logic                      r_out_valid;
  logic                      w_cfg_hs;
  logic                      w_in_hs;
  logic                      w_out_hs;
  logic [DATA_OUT_WIDTH-1:0] w_rd_data;

  // A cfg_start while loading takes priority, so that cycle's beat is refused
  // rather than written and then discarded.
  assign cfg_ready = (r_state == LOAD) && !cfg_start;

  // Lookups are taken only in RUN, and only when the output register is free
  // or is being emptied this cycle. A cfg_start in RUN does not block the
  // same-cycle lookup; the state change removes ready from the next cycle.
  assign data_in_0_ready = (r_state == RUN) && (!r_out_valid || data_out_0_ready);

  assign w_cfg_hs = cfg_valid && cfg_ready;
  assign w_in_hs  = data_in_0_valid && data_in_0_ready;
  assign w_out_hs = r_out_valid && data_out_0_ready;

  // State, load address and loaded flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= EMPTY;
      r_addr   <= '0;
      r_loaded <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_addr   <= w_addr_next;
      r_loaded <= (w_state_next == RUN);
    end
  end

  // Next-state and load address sequencing.
  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    case (r_state)
      EMPTY: begin
        if (cfg_start) begin
          w_state_next = LOAD;
          w_addr_next  = '0;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          w_addr_next = '0;
        end else if (w_cfg_hs) begin
          // Incrementing past the last entry wraps the address to zero.
          w_addr_next = r_addr + 1'b1;
          if (r_addr == ADDR_LAST) begin
            w_state_next = RUN;
          end
        end
      end
      RUN: begin
        if (cfg_start) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        // The pending output leaves with the old table value before any
        // entry is overwritten.
        if (!r_out_valid || data_out_0_ready) begin
          w_state_next = LOAD;
          w_addr_next  = '0;
        end
      end
      default: begin
        w_state_next = EMPTY;
        w_addr_next  = '0;
      end
    endcase
  end

  // Output valid: set by an accepted lookup, cleared by a delivery with no
  // lookup replacing it; held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
    end else if (w_in_hs) begin
      r_out_valid <= 1'b1;
    end else if (w_out_hs) begin
      r_out_valid <= 1'b0;
    end
  end

  activation_lut_mem #(
    .ADDR_WIDTH (DATA_IN_WIDTH),
    .DATA_WIDTH (DATA_OUT_WIDTH)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_cfg_hs),
    .i_wr_addr (r_addr),
    .i_wr_data (cfg_data),
    .i_rd_en   (w_in_hs),
    .i_rd_addr (data_in_0),
    .o_rd_data (w_rd_data)
  );

  assign lut_loaded       = r_loaded;
  assign data_out_0       = w_rd_data;
  assign data_out_0_valid = r_out_valid;
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_prog_activation_lut.sv
// Directed bench for prog_activation_lut: table loads, lookups, backpressure,
// reloads and asynchronous resets.
module tb_prog_activation_lut;
  import prog_activation_lut_pkg::*;

  localparam int IW = 8;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_start;
  logic [OW-1:0] cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          lut_loaded;
  logic [IW-1:0] data_in_0;
  logic          data_in_0_valid;
  logic          data_in_0_ready;
  logic [OW-1:0] data_out_0;
  logic          data_out_0_valid;
  logic          data_out_0_ready;
  lut_state_t    dbg_state;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [OW-1:0] model_tbl [256];
  logic [OW-1:0] exp_q[$];

  logic [IW-1:0] tp_in  [3] = '{8'h01, 8'h02, 8'h90};
  logic [OW-1:0] tp_exp [3] = '{8'h01, 8'h02, 8'h00};

  // Clock and reset block
  always #5 clk = ~clk;

  prog_activation_lut #(
    .DATA_IN_WIDTH  (IW),
    .DATA_OUT_WIDTH (OW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_start        (cfg_start),
    .cfg_data         (cfg_data),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .lut_loaded       (lut_loaded),
    .data_in_0        (data_in_0),
    .data_in_0_valid  (data_in_0_valid),
    .data_in_0_ready  (data_in_0_ready),
    .data_out_0       (data_out_0),
    .data_out_0_valid (data_out_0_valid),
    .data_out_0_ready (data_out_0_ready),
    .dbg_state        (dbg_state)
  );

  // Table images: 1 = SiLU-like, 2 = xor A5, 3 = constant EE, other = xor 5A
  function automatic logic [OW-1:0] tbl_val(input int tbl, input int a);
    logic [7:0] av;
    av = a[7:0];
    case (tbl)
      1:       return (av < 8'h80) ? av : 8'h00;
      2:       return av ^ 8'hA5;
      3:       return 8'hEE;
      default: return av ^ 8'h5A;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: optionally pulse cfg_start, then stream 256 entries with
  // cfg_valid high one cycle in every gap+1 cycles, counting accepted beats.
  task automatic load_table(input int tbl, input int gap, input bit do_start);
    int idx;
    int phase;
    int cyc;
    if (do_start) begin
      cfg_valid = 1'b0;
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
    end
    idx   = 0;
    phase = 0;
    cyc   = 0;
    while (idx < 256 && cyc < 3000) begin
      cfg_valid = ((phase % (gap + 1)) == 0);
      cfg_data  = tbl_val(tbl, idx);
      #1;
      if (cfg_valid && cfg_ready) begin
        if (idx == 255) check("loaded_before_last_beat", lut_loaded, 0);
        idx++;
      end
      phase++;
      cyc++;
      step();
    end
    cfg_valid = 1'b0;
    check("load_beats_accepted", idx, 256);
    check("loaded_after_last_beat", lut_loaded, 1);
    check("state_run_after_load", dbg_state, RUN);
    for (int i = 0; i < 256; i++) model_tbl[i] = tbl_val(tbl, i);
  endtask

  // Driver: single lookup with downstream ready, checks 1-cycle latency
  task automatic lookup(input logic [IW-1:0] a, input logic [OW-1:0] exp, input string tag);
    data_in_0        = a;
    data_in_0_valid  = 1'b1;
    data_out_0_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, data_in_0_ready, 1);
    step();
    data_in_0_valid = 1'b0;
    check({tag, "_out_valid"}, data_out_0_valid, 1);
    check({tag, "_out_data"}, data_out_0, exp);
    step();
    check({tag, "_out_cleared"}, data_out_0_valid, 0);
  endtask

  initial begin
    int          sent;
    int          recv;
    int          cyc;
    bit          stall_active;
    logic [OW-1:0] stall_data;
    int          beats;

    rst_n            = 1'b0;
    cfg_start        = 1'b0;
    cfg_data         = '0;
    cfg_valid        = 1'b1;
    data_in_0        = '0;
    data_in_0_valid  = 1'b1;
    data_out_0_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Reset state (inputs active to show they are ignored)
    check("rst_out_data", data_out_0, 0);
    check("rst_out_valid", data_out_0_valid, 0);
    check("rst_loaded", lut_loaded, 0);
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_in_ready", data_in_0_ready, 0);
    check("rst_state", dbg_state, EMPTY);
    rst_n = 1'b1;
    step();
    check("empty_ignores_cfg_valid", dbg_state, EMPTY);
    check("empty_in_ready", data_in_0_ready, 0);
    data_in_0_valid = 1'b0;

    // cfg_start in EMPTY with a beat present: start wins, beat not written
    cfg_data  = 8'h77;
    cfg_start = 1'b1;
    #1;
    check("empty_start_cfg_ready", cfg_ready, 0);
    step();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    check("state_load_after_start", dbg_state, LOAD);
    load_table(1, 0, 1'b0);

    // Directed SiLU lookups
    lookup(8'h40, 8'h40, "silu_40");
    lookup(8'h7F, 8'h7F, "silu_7f");
    lookup(8'h85, 8'h00, "silu_85");
    lookup(8'hFF, 8'h00, "silu_ff");
    lookup(8'h00, 8'h00, "silu_00");

    // Full throughput: back-to-back inputs, one result per cycle
    data_out_0_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in_0       = tp_in[i];
      data_in_0_valid = 1'b1;
      #1;
      check("tp_in_ready", data_in_0_ready, 1);
      step();
      check("tp_out_valid", data_out_0_valid, 1);
      check("tp_out_data", data_out_0, tp_exp[i]);
    end
    data_in_0_valid = 1'b0;
    step();
    check("tp_out_cleared", data_out_0_valid, 0);

    // Random backpressure with scoreboard
    sent = 0;
    recv = 0;
    cyc  = 0;
    stall_active = 1'b0;
    stall_data   = '0;
    while ((sent < 1000 || exp_q.size() > 0) && cyc < 20000) begin
      if (stall_active) begin
        check("bp_stall_valid", data_out_0_valid, 1);
        check("bp_stall_data", data_out_0, stall_data);
      end
      data_in_0_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      data_in_0        = IW'($urandom_range(0, 255));
      data_out_0_ready = 1'($urandom_range(0, 1));
      #1;
      stall_active = data_out_0_valid && !data_out_0_ready;
      stall_data   = data_out_0;
      if (data_out_0_valid && data_out_0_ready) begin
        check("bp_output_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("bp_data", data_out_0, exp_q.pop_front());
        recv++;
      end
      if (data_in_0_valid && data_in_0_ready) begin
        exp_q.push_back(model_tbl[data_in_0]);
        sent++;
      end
      cyc++;
      step();
    end
    data_in_0_valid  = 1'b0;
    data_out_0_ready = 1'b1;
    check("bp_sent", sent, 1000);
    check("bp_recv", recv, 1000);
    step();

    // Reload mid-stream with a stalled output pending
    data_out_0_ready = 1'b0;
    data_in_0        = 8'h20;
    data_in_0_valid  = 1'b1;
    #1;
    check("rm_first_in_ready", data_in_0_ready, 1);
    step();
    data_in_0_valid = 1'b0;
    check("rm_pending_valid", data_out_0_valid, 1);
    check("rm_pending_data", data_out_0, 8'h20);
    cfg_start = 1'b1;
    #1;
    check("rm_start_in_ready", data_in_0_ready, 0);
    step();
    cfg_start       = 1'b0;
    data_in_0       = 8'h10;
    data_in_0_valid = 1'b1;
    #1;
    check("rm_loaded_low", lut_loaded, 0);
    check("rm_in_ready_low", data_in_0_ready, 0);
    check("rm_state_drain", dbg_state, DRAIN);
    check("rm_hold_valid", data_out_0_valid, 1);
    check("rm_hold_data", data_out_0, 8'h20);
    step();
    check("rm_still_drain", dbg_state, DRAIN);
    check("rm_hold_data2", data_out_0, 8'h20);
    data_out_0_ready = 1'b1;
    #1;
    check("rm_drain_in_ready", data_in_0_ready, 0);
    step();
    data_in_0_valid = 1'b0;
    check("rm_delivered", data_out_0_valid, 0);
    check("rm_state_load", dbg_state, LOAD);
    load_table(2, 0, 1'b0);
    lookup(8'h10, 8'hB5, "rm_new_10");

    // cfg_start during LOAD after 100 beats, with a beat on the same cycle
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    beats = 0;
    cyc   = 0;
    while (beats < 100 && cyc < 200) begin
      cfg_valid = 1'b1;
      cfg_data  = tbl_val(3, beats);
      #1;
      if (cfg_ready) beats++;
      cyc++;
      step();
    end
    check("rs_first_pass_beats", beats, 100);
    cfg_valid = 1'b1;
    cfg_data  = 8'h99;
    cfg_start = 1'b1;
    #1;
    check("rs_start_cfg_ready", cfg_ready, 0);
    step();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    check("rs_state_load", dbg_state, LOAD);
    check("rs_not_loaded", lut_loaded, 0);
    load_table(4, 0, 1'b0);
    lookup(8'h05, 8'h5F, "rs_entry_05");
    lookup(8'h00, 8'h5A, "rs_entry_00");
    lookup(8'h64, 8'h3E, "rs_entry_64");

    // Gapped configuration stream (1 on, 2 off)
    load_table(1, 2, 1'b1);
    lookup(8'h33, 8'h33, "gap_33");
    lookup(8'hC0, 8'h00, "gap_c0");
    lookup(8'h01, 8'h01, "gap_01");

    // Asynchronous reset in RUN with an output pending
    data_out_0_ready = 1'b0;
    data_in_0        = 8'h55;
    data_in_0_valid  = 1'b1;
    step();
    data_in_0_valid = 1'b0;
    check("rr_pending_data", data_out_0, 8'h55);
    #3;
    rst_n = 1'b0;
    #1;
    check("rr_out_data", data_out_0, 0);
    check("rr_out_valid", data_out_0_valid, 0);
    check("rr_loaded", lut_loaded, 0);
    check("rr_in_ready", data_in_0_ready, 0);
    check("rr_state", dbg_state, EMPTY);
    step();
    rst_n            = 1'b1;
    data_in_0_valid  = 1'b1;
    data_out_0_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rr_in_ready_blocked", data_in_0_ready, 0);
      step();
    end
    data_in_0_valid = 1'b0;

    // Asynchronous reset in LOAD after a partial load
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = tbl_val(2, i);
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("rl_cfg_ready", cfg_ready, 0);
    check("rl_state", dbg_state, EMPTY);
    check("rl_loaded", lut_loaded, 0);
    check("rl_out_valid", data_out_0_valid, 0);
    check("rl_out_data", data_out_0, 0);
    step();
    rst_n     = 1'b1;
    cfg_valid = 1'b0;
    data_in_0_valid = 1'b1;
    #1;
    check("rl_in_ready_blocked", data_in_0_ready, 0);
    step();
    data_in_0_valid = 1'b0;
    load_table(1, 0, 1'b1);
    lookup(8'h40, 8'h40, "rl_reload_40");
    lookup(8'h10, 8'h10, "rl_reload_10");
    lookup(8'h90, 8'h00, "rl_reload_90");

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
